// File: rtl/ram_latency_model.sv
// Word-addressed RAM behind a FREE/BUSY/ACCESS/ERROR handshake; ACCESS appears LAT cycles after a stable request.
// Requester holds REN/WEN until ACCESS; changing or dropping the request mid-flight aborts it without touching memory.
module ram_latency_model #(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} fsm_t;

  fsm_t                 state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 op_q, op_d;
  logic [31:0]          data_q, data_d;

  logic [31:0]          mem [2**ADDR_BITS];

  logic                 any_req, both_req, aligned, in_range, req_ok, match, start;
  logic [ADDR_BITS-1:0] word_addr;
  logic                 load_en, mem_we;
  logic [ADDR_BITS-1:0] load_idx;

  assign any_req   = ramREN | ramWEN;
  assign both_req  = ramREN & ramWEN;
  assign aligned   = (ramaddr[1:0] == 2'b00);
  assign in_range  = ((ramaddr >> (ADDR_BITS + 2)) == 32'd0);
  assign req_ok    = (ramREN ^ ramWEN) & aligned & in_range;
  assign word_addr = ramaddr[ADDR_BITS+1:2];
  assign match     = (word_addr == addr_q) && (ramWEN == op_q);

  // A changed-but-valid request in WAIT restarts at once, so its latency counts from its own first cycle.
  assign start = req_ok && ((state_q == IDLE) || ((state_q == WAIT) && !match));

  always_comb begin
    ramstate = BUSY;
    if (both_req || (any_req && !(aligned && in_range))) begin
      ramstate = ERROR;
    end else if (!any_req) begin
      ramstate = FREE;
    end else if ((state_q == DONE) && match) begin
      ramstate = ACCESS;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    op_d     = op_q;
    data_d   = data_q;
    load_en  = 1'b0;
    load_idx = addr_q;
    mem_we   = 1'b0;
    if (start) begin
      addr_d = word_addr;
      op_d   = ramWEN;
      data_d = ramstore;
      if (LAT == 1) begin
        state_d  = DONE;
        cnt_d    = 4'd0;
        load_en  = !ramWEN;
        load_idx = word_addr;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LAT - 1);
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT: begin
          if (!req_ok) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_d = DONE;
            cnt_d   = 4'd0;
            load_en = !op_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          mem_we  = req_ok && match && op_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      data_q  <= 32'h0;
      ramload <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      if (load_en) begin
        ramload <= mem[load_idx];
      end
    end
  end

  // Array is deliberately outside the reset domain; contents survive nRST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: three instances (LAT=2, LAT=1, LAT=3) against a transaction-level memory model.
module tb_ram_latency_model;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [2:0]  ren, wen;
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load0, load1, load2;
  logic [1:0]  st0, st1, st2;

  logic [31:0] mm [3][16];
  logic [31:0] last_load [3];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  ram_latency_model #(.LAT(2), .ADDR_BITS(10)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
    .ramstore(store[0]), .ramload(load0), .ramstate(st0));
  ram_latency_model #(.LAT(1), .ADDR_BITS(10)) u_lat1 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
    .ramstore(store[1]), .ramload(load1), .ramstate(st1));
  ram_latency_model #(.LAT(3), .ADDR_BITS(10)) u_lat3 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[2]), .ramWEN(wen[2]), .ramaddr(addr[2]),
    .ramstore(store[2]), .ramload(load2), .ramstate(st2));

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic [1:0] st_of(input int k);
    return (k == 0) ? st0 : ((k == 1) ? st1 : st2);
  endfunction

  function automatic logic [31:0] load_of(input int k);
    return (k == 0) ? load0 : ((k == 1) ? load1 : load2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren[k]   = r;
    wen[k]   = w;
    addr[k]  = a;
    store[k] = d;
  endtask

  // Request is free again: ramstate FREE and ramload still holding its last value.
  task automatic expect_free(input int k, input string tag);
    @(negedge CLK);
    check($sformatf("%s k%0d free", tag, k), 32'(st_of(k)), 32'(FREE));
    check($sformatf("%s k%0d hold", tag, k), load_of(k), last_load[k]);
    tick();
  endtask

  // Full held transaction: BUSY for LAT cycles, ACCESS on cycle LAT, then drop.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int wi;
    wi = int'(a[5:2]);
    drive(k, !w, w, a, d);
    for (int c = 0; c <= lat_of(k); c++) begin
      @(negedge CLK);
      check($sformatf("%s k%0d st c%0d", tag, k, c), 32'(st_of(k)),
            (c == lat_of(k)) ? 32'(ACCESS) : 32'(BUSY));
      if (c == lat_of(k) && !w) begin
        check($sformatf("%s k%0d load", tag, k), load_of(k), mm[k][wi]);
        last_load[k] = mm[k][wi];
      end
      tick();
    end
    if (w) mm[k][wi] = d;
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_free(k, tag);
  endtask

  typedef struct {
    int          k;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, ERROR};
    tbl[1] = '{0, 1'b0, 1'b1, 32'h0000_0012, 32'h0BAD_F00D, ERROR};
    tbl[2] = '{0, 1'b0, 1'b1, 32'h0000_1010, 32'h0BAD_F00D, ERROR};
    tbl[3] = '{0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, ERROR};
    tbl[4] = '{1, 1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_BABE, ERROR};
    tbl[5] = '{1, 1'b0, 1'b1, 32'h0000_0006, 32'hCAFE_BABE, ERROR};
    tbl[6] = '{2, 1'b0, 1'b1, 32'h8000_0008, 32'h5A5A_5A5A, ERROR};
    tbl[7] = '{2, 1'b0, 1'b0, 32'h0000_0008, 32'h5A5A_5A5A, FREE};

    ren = '0;
    wen = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0;
      store[k] = 32'h0;
      last_load[k] = 32'h0;
    end

    // Reset: outputs cleared, ramstate purely a function of inputs.
    nRST = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h4, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst load0", load0, 32'h0);
    check("rst load1", load1, 32'h0);
    check("rst load2", load2, 32'h0);
    check("rst st0 busy", 32'(st0), 32'(BUSY));
    check("rst st1 error", 32'(st1), 32'(ERROR));
    check("rst st2 free", 32'(st2), 32'(FREE));
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    nRST = 1'b1;
    tick();

    // Fill the modelled window so every later read has a known answer.
    for (int k = 0; k < 3; k++)
      for (int wi = 0; wi < 16; wi++)
        txn(k, 1'b1, 32'(wi * 4), $urandom, "init");

    // Write then read, LAT=2 and LAT=1.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
    txn(0, 1'b0, 32'h10, 32'h0, "rd10");
    txn(1, 1'b1, 32'h4, 32'h1234_5678, "wr4");
    txn(1, 1'b0, 32'h4, 32'h0, "rd4");

    // Abort by address change in cycle 1, LAT=3.
    drive(2, 1'b0, 1'b1, 32'h8, 32'hAAAA_5555);
    @(negedge CLK);
    check("abort c0", 32'(st2), 32'(BUSY));
    tick();
    addr[2] = 32'hC;
    for (int c = 0; c <= 3; c++) begin
      @(negedge CLK);
      check($sformatf("abort chg c%0d", c), 32'(st2), (c == 3) ? 32'(ACCESS) : 32'(BUSY));
      tick();
    end
    mm[2][3] = 32'hAAAA_5555;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_free(2, "abort");
    txn(2, 1'b0, 32'h8, 32'h0, "abort rd8");
    txn(2, 1'b0, 32'hC, 32'h0, "abort rdC");

    // Error table: each error held, then a clean read proves memory untouched.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      for (int c = 0; c < 4; c++) begin
        @(negedge CLK);
        check($sformatf("tbl%0d st c%0d", i, c), 32'(st_of(tbl[i].k)), 32'(tbl[i].exp));
        tick();
      end
      drive(tbl[i].k, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      txn(tbl[i].k, 1'b0, tbl[i].a & 32'h3C, 32'h0, $sformatf("tbl%0d rd", i));
    end

    // Back-to-back held read, LAT=2.
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      check($sformatf("b2b st c%0d", c), 32'(st0),
            (c == 2 || c == 5) ? 32'(ACCESS) : 32'(BUSY));
      if (c == 2 || c == 5) check($sformatf("b2b load c%0d", c), load0, mm[0][1]);
      tick();
    end
    last_load[0] = mm[0][1];
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_free(0, "b2b");

    // Reset while a write of 0x20 sits in WAIT.
    txn(0, 1'b0, 32'h20, 32'h0, "prerst rd");
    drive(0, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF);
    @(negedge CLK);
    check("rstw c0", 32'(st0), 32'(BUSY));
    tick();
    @(negedge CLK);
    check("rstw c1", 32'(st0), 32'(BUSY));
    nRST = 1'b0;
    #1;
    check("rstw load0", load0, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) last_load[k] = 32'h0;
    tick();
    expect_free(0, "rstw");
    txn(0, 1'b0, 32'h20, 32'h0, "rstw rd20");

    // Randomised traffic: full transactions, early drops, and error requests.
    for (int it = 0; it < 200; it++) begin
      int k, m, wi, h, kind;
      logic w;
      logic [31:0] a, d;
      k  = $urandom_range(0, 2);
      m  = $urandom_range(0, 9);
      wi = $urandom_range(0, 15);
      a  = 32'(wi * 4);
      d  = $urandom;
      w  = 1'($urandom_range(0, 1));
      if (m == 0) begin
        kind = $urandom_range(0, 2);
        if (kind == 0) drive(k, 1'b1, 1'b1, a, d);
        else if (kind == 1) drive(k, 1'b0, 1'b1, a + 32'($urandom_range(1, 3)), d);
        else drive(k, 1'b0, 1'b1, a | (32'h1 << $urandom_range(12, 31)), d);
        h = $urandom_range(1, 3);
        for (int c = 0; c < h; c++) begin
          @(negedge CLK);
          check($sformatf("rnd%0d err c%0d", it, c), 32'(st_of(k)), 32'(ERROR));
          tick();
        end
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_free(k, $sformatf("rnd%0d err", it));
      end else if (m == 1) begin
        h = $urandom_range(1, lat_of(k));
        drive(k, !w, w, a, d);
        for (int c = 0; c < h; c++) begin
          @(negedge CLK);
          check($sformatf("rnd%0d drop c%0d", it, c), 32'(st_of(k)), 32'(BUSY));
          tick();
        end
        if (!w && h == lat_of(k)) last_load[k] = mm[k][wi];
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_free(k, $sformatf("rnd%0d drop", it));
      end else begin
        txn(k, w, a, d, $sformatf("rnd%0d", it));
      end
    end

    // Final sweep: every modelled word in every instance.
    for (int k = 0; k < 3; k++)
      for (int wi = 0; wi < 16; wi++)
        txn(k, 1'b0, 32'(wi * 4), 32'h0, "final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
